// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles little-endian words into instruction memory, then releases the core.
// Optional trailing XOR checksum check enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W-1:0] words_loaded
);

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_e;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERR} state_e;
`endif

  state_e            state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       words_left_q;
  logic [1:0]        lane_q;
  logic [23:0]       buf_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_run_q;
  logic              load_err_q;
  logic [ADDR_W-1:0] words_loaded_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        xfer;
  logic [15:0] len_d;
  logic [31:0] word_d;

  assign xfer   = in_valid && in_ready_q;
  assign len_d  = {in_data, len_lo_q};
  assign word_d = {in_data, buf_q};

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LEN_LO;
      len_lo_q       <= 8'd0;
      words_left_q   <= 16'd0;
      lane_q         <= 2'd0;
      buf_q          <= 24'd0;
      in_ready_q     <= 1'b1;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
      cpu_run_q      <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q         <= 8'd0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        LEN_LO: begin
          if (xfer) begin
            len_lo_q <= in_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            if (len_d == 16'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              state_q <= CSUM;
`else
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              cpu_run_q  <= 1'b1;
`endif
            end else if (32'(len_d) > MAX_WORDS) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              load_err_q <= 1'b1;
            end else begin
              state_q      <= DATA;
              words_left_q <= len_d;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            lane_q <= lane_q + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            case (lane_q)
              2'd0: buf_q[7:0]   <= in_data;
              2'd1: buf_q[15:8]  <= in_data;
              2'd2: buf_q[23:16] <= in_data;
              default: begin
                // Lane 3 completes the word: issue the write next cycle while bytes keep flowing.
                mem_we_q       <= 1'b1;
                mem_addr_q     <= ADDR_W'(BASE_ADDR) + words_loaded_q;
                mem_wdata_q    <= word_d;
                words_loaded_q <= words_loaded_q + ADDR_W'(1);
                words_left_q   <= words_left_q - 16'd1;
                if (words_left_q == 16'd1) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                  state_q <= CSUM;
`else
                  state_q    <= DONE;
                  in_ready_q <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q   <= DONE;
              cpu_run_q <= 1'b1;
            end else begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          // Entered on the last lane-3 byte; run starts once the final write pulse has gone out.
          in_ready_q <= 1'b0;
          cpu_run_q  <= 1'b1;
        end
        ERR: begin
          in_ready_q <= 1'b0;
          cpu_run_q  <= 1'b0;
          load_err_q <= 1'b1;
        end
        default: begin
          state_q    <= ERR;
          in_ready_q <= 1'b0;
          load_err_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by the stimulus and checked by a monitor.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_boot_loader #(.ADDR_W(16), .BASE_ADDR(0), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  int         total = 0;
  int         bad = 0;
  int         n_wr = 0;
  int         acc = 0;
  bit         mark = 1'b0;
  wr_t        sb[$];
  logic [7:0] stim[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

  // Monitor: a write must follow a lane-3 transfer by exactly one cycle and match the queue head.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      n_wr++;
      chk("we_latency", 32'(mark), 32'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
    if (!rst_n) begin
      acc  = 0;
      mark = 1'b0;
    end else begin
      mark = in_valid && in_ready && (acc >= 2) && (((acc - 2) % 4) == 3);
      if (in_valid && in_ready) acc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: byte %h not accepted, in_ready=%b", b, in_ready);
    end
    in_valid = 1'b0;
    if (gap > 0) step(gap);
  endtask

  task automatic send_all(input int gap);
    for (int i = 0; i < stim.size(); i++) send(stim[i], gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    step(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic load_two(input int gap);
    exp_wr(16'h0000, 32'h0000_0013);
    exp_wr(16'h0001, 32'h4021_00B3);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h40};
`ifdef IMEM_BOOT_CHECKSUM_EN
    stim.push_back(8'hC1);
`endif
    send_all(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Back-to-back two-word load with precise pulse/run timing.
    load_two(0);
`ifndef IMEM_BOOT_CHECKSUM_EN
    chk("t1_we_pulse", 32'(mem_we), 32'd1);
    chk("t1_words_at_pulse", 32'(words_loaded), 32'd2);
    chk("t1_run_early", 32'(cpu_run), 32'd0);
`endif
    step(1);
    chk("t1_run", 32'(cpu_run), 32'd1);
    chk("t1_we_low", 32'(mem_we), 32'd0);
    chk("t1_ready_low", 32'(in_ready), 32'd0);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_addr_hold", 32'(mem_addr), 32'd1);
    chk("t1_data_hold", mem_wdata, 32'h4021_00B3);

    // Same image with 3-cycle stalls between bytes.
    do_reset();
    load_two(3);
    chk("t2_run", 32'(cpu_run), 32'd1);
    chk("t2_words", 32'(words_loaded), 32'd2);
    chk("t2_ready_low", 32'(in_ready), 32'd0);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Oversized length goes to the error state without writes.
    do_reset();
    n_wr = 0;
    stim = '{8'h01, 8'h04};
    send_all(0);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_ready_low", 32'(in_ready), 32'd0);
    chk("t3_run_low", 32'(cpu_run), 32'd0);
    step(5);
    chk("t3_err_sticky", 32'(load_err), 32'd1);
    chk("t3_run_still_low", 32'(cpu_run), 32'd0);
    chk("t3_no_writes", 32'(n_wr), 32'd0);

    // Empty image releases the core immediately.
    do_reset();
    n_wr = 0;
    stim = '{8'h00, 8'h00};
`ifdef IMEM_BOOT_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    send_all(0);
    chk("t4_run", 32'(cpu_run), 32'd1);
    chk("t4_ready_low", 32'(in_ready), 32'd0);
    chk("t4_err_low", 32'(load_err), 32'd0);
    step(2);
    chk("t4_no_writes", 32'(n_wr), 32'd0);

    // Reset mid-load discards the partial word; a fresh load restarts at addr 0.
    do_reset();
    n_wr = 0;
    exp_wr(16'h0000, 32'h0000_0013);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00};
    send_all(0);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_we_zero", 32'(mem_we), 32'd0);
    chk("t5_words_zero", 32'(words_loaded), 32'd0);
    chk("t5_addr_zero", 32'(mem_addr), 32'd0);
    chk("t5_ready_one", 32'(in_ready), 32'd1);
    chk("t5_one_write", 32'(n_wr), 32'd1);
    step(1);
    rst_n = 1'b1;
    load_two(0);
    step(2);
    chk("t5_reload_run", 32'(cpu_run), 32'd1);
    chk("t5_reload_words", 32'(words_loaded), 32'd2);
    chk("t5_total_writes", 32'(n_wr), 32'd3);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match releases the core; mismatch errors after the write.
    do_reset();
    exp_wr(16'h0000, 32'h4433_2211);
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_all(0);
    step(1);
    chk("t6_run", 32'(cpu_run), 32'd1);
    chk("t6_err_low", 32'(load_err), 32'd0);
    do_reset();
    n_wr = 0;
    exp_wr(16'h0000, 32'h4433_2211);
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_all(0);
    step(2);
    chk("t6_bad_err", 32'(load_err), 32'd1);
    chk("t6_bad_run_low", 32'(cpu_run), 32'd0);
    chk("t6_bad_written", 32'(n_wr), 32'd1);
`endif

    step(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
